// File: rtl/tipi_rpi_to_ti.sv
// RPi->TI mailbox: serial RPi frames land in RD/RC, which the TI reads as memory-mapped bytes.
// Latency: every RPi/TI input acts SYNC_STAGES+1 clk cycles after it changes.
// Backpressure: none; a commit that hits a register under TI read is parked until the read ends.
module tipi_rpi_to_ti #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] ADDR_RD     = 16'h5FFB,
    parameter logic [15:0] ADDR_RC     = 16'h5FF9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        r_clk,
    input  logic        r_dout,
    input  logic        r_le,
    input  logic        r_rt,
    input  logic [15:0] ti_a,        // TI A0 (the TI's MSB) is bit 15 here
    input  logic        ti_memen,
    input  logic        ti_dbin,
    output logic [7:0]  ti_dout,
    output logic        tipi_data_out,
    output logic [7:0]  rd_q,
    output logic [7:0]  rc_q,
    output logic        rd_pending,
    output logic        rc_pending,
    output logic        frame_err
);

    localparam int N = SYNC_STAGES;

    logic [N-1:0] clk_sy, dout_sy, le_sy, rt_sy, memen_sy, dbin_sy;
    logic         clk_s, dout_s, le_s, rt_s, memen_s, dbin_s;
    logic         clk_d, le_d, rd_act_d, rc_act_d;
    logic [15:0]  a_q;
    logic [7:0]   sh;
    logic [3:0]   cnt;
    logic [7:0]   rd_sh, rc_sh;
    logic         rd_sh_vld, rc_sh_vld;

    logic clk_rise, le_rise, commit_ok, rd_wr, rc_wr;
    logic rd_act, rc_act, rd_fall, rc_fall;

    assign clk_s   = clk_sy[N-1];
    assign dout_s  = dout_sy[N-1];
    assign le_s    = le_sy[N-1];
    assign rt_s    = rt_sy[N-1];
    assign memen_s = memen_sy[N-1];
    assign dbin_s  = dbin_sy[N-1];

    assign clk_rise  = clk_s & ~clk_d;
    assign le_rise   = le_s & ~le_d;
    assign commit_ok = le_rise & (cnt == 4'd8);
    assign rd_wr     = commit_ok & ~rt_s;
    assign rc_wr     = commit_ok & rt_s;

    assign rd_act  = ~memen_s & dbin_s & (a_q == ADDR_RD);
    assign rc_act  = ~memen_s & dbin_s & (a_q == ADDR_RC);
    assign rd_fall = rd_act_d & ~rd_act;
    assign rc_fall = rc_act_d & ~rc_act;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_sy        <= '0;
            dout_sy       <= '0;
            le_sy         <= '0;
            rt_sy         <= '0;
            memen_sy      <= '1;
            dbin_sy       <= '0;
            clk_d         <= 1'b0;
            le_d          <= 1'b0;
            rd_act_d      <= 1'b0;
            rc_act_d      <= 1'b0;
            a_q           <= '0;
            sh            <= '0;
            cnt           <= '0;
            rd_sh         <= '0;
            rc_sh         <= '0;
            rd_sh_vld     <= 1'b0;
            rc_sh_vld     <= 1'b0;
            rd_q          <= '0;
            rc_q          <= '0;
            rd_pending    <= 1'b0;
            rc_pending    <= 1'b0;
            frame_err     <= 1'b0;
            ti_dout       <= '0;
            tipi_data_out <= 1'b1;
        end else begin
            clk_sy   <= {clk_sy[N-2:0], r_clk};
            dout_sy  <= {dout_sy[N-2:0], r_dout};
            le_sy    <= {le_sy[N-2:0], r_le};
            rt_sy    <= {rt_sy[N-2:0], r_rt};
            memen_sy <= {memen_sy[N-2:0], ti_memen};
            dbin_sy  <= {dbin_sy[N-2:0], ti_dbin};
            a_q      <= ti_a;
            clk_d    <= clk_s;
            le_d     <= le_s;
            rd_act_d <= rd_act;
            rc_act_d <= rc_act;

            frame_err <= le_rise & (cnt != 4'd8);

            // A latch edge swallows any shift edge arriving in the same cycle.
            if (le_rise) begin
                cnt <= '0;
            end else if (clk_rise) begin
                sh <= {sh[6:0], dout_s};
                if (cnt != 4'd9)
                    cnt <= cnt + 4'd1;
            end

            if (rd_wr && rd_act) begin
                rd_sh     <= sh;
                rd_sh_vld <= 1'b1;
            end else if (rd_wr) begin
                rd_q      <= sh;
                rd_sh_vld <= 1'b0;
            end else if (rd_fall && rd_sh_vld) begin
                rd_q      <= rd_sh;
                rd_sh_vld <= 1'b0;
            end
            if ((rd_wr && !rd_act) || (rd_fall && rd_sh_vld))
                rd_pending <= 1'b1;
            else if (rd_fall)
                rd_pending <= 1'b0;

            if (rc_wr && rc_act) begin
                rc_sh     <= sh;
                rc_sh_vld <= 1'b1;
            end else if (rc_wr) begin
                rc_q      <= sh;
                rc_sh_vld <= 1'b0;
            end else if (rc_fall && rc_sh_vld) begin
                rc_q      <= rc_sh;
                rc_sh_vld <= 1'b0;
            end
            if ((rc_wr && !rc_act) || (rc_fall && rc_sh_vld))
                rc_pending <= 1'b1;
            else if (rc_fall)
                rc_pending <= 1'b0;

            if (rd_act) begin
                tipi_data_out <= 1'b0;
                ti_dout       <= rd_q;
            end else if (rc_act) begin
                tipi_data_out <= 1'b0;
                ti_dout       <= rc_q;
            end else begin
                tipi_data_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tipi_rpi_to_ti.sv
// Directed plus randomized frames against a byte-level mailbox model.
module tb_tipi_rpi_to_ti;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        r_clk = 1'b0, r_dout = 1'b0, r_le = 1'b0, r_rt = 1'b0;
    logic [15:0] ti_a = 16'h0000;
    logic        ti_memen = 1'b1, ti_dbin = 1'b0;
    logic [7:0]  ti_dout, rd_q, rc_q;
    logic        tipi_data_out, rd_pending, rc_pending, frame_err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_rd = 8'h00, exp_rc = 8'h00;
    logic       exp_rdp = 1'b0, exp_rcp = 1'b0;

    tipi_rpi_to_ti dut (
        .clk(clk), .rst_n(rst_n), .r_clk(r_clk), .r_dout(r_dout), .r_le(r_le), .r_rt(r_rt),
        .ti_a(ti_a), .ti_memen(ti_memen), .ti_dbin(ti_dbin), .ti_dout(ti_dout),
        .tipi_data_out(tipi_data_out), .rd_q(rd_q), .rc_q(rc_q),
        .rd_pending(rd_pending), .rc_pending(rc_pending), .frame_err(frame_err)
    );

    always #10 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            r_dout = v[i];
            tick(1);
            r_clk = 1'b1;
            tick(4);
            r_clk = 1'b0;
            tick(4);
        end
    endtask

    // Pulses r_le and counts frame_err pulses seen over the following window.
    task automatic commit(input logic rt, output int errs);
        errs = 0;
        r_rt = rt;
        tick(1);
        r_le = 1'b1;
        repeat (5) begin tick(1); errs += int'(frame_err); end
        r_le = 1'b0;
        repeat (5) begin tick(1); errs += int'(frame_err); end
    endtask

    // Model: a frame of exactly 8 bits replaces the target byte and raises its pending flag.
    task automatic model_frame(input logic [15:0] v, input int n, input logic rt, output int exp_err);
        exp_err = (n == 8) ? 0 : 1;
        if (n == 8) begin
            if (rt) begin exp_rc = v[7:0]; exp_rcp = 1'b1; end
            else    begin exp_rd = v[7:0]; exp_rdp = 1'b1; end
        end
    endtask

    task automatic frame(input string tag, input logic [15:0] v, input int n, input logic rt);
        int errs, exp_err;
        send_bits(v, n);
        commit(rt, errs);
        model_frame(v, n, rt, exp_err);
        chk({tag, "_err"}, errs, exp_err);
        chk({tag, "_rd"}, rd_q, exp_rd);
        chk({tag, "_rc"}, rc_q, exp_rc);
        chk({tag, "_pend"}, {rd_pending, rc_pending}, {exp_rdp, exp_rcp});
    endtask

    // A completed TI read returns the modelled byte and clears that register's pending flag.
    task automatic ti_read(input string tag, input logic [15:0] addr);
        logic [7:0] want;
        logic       hit;
        hit  = (addr == 16'h5FFB) || (addr == 16'h5FF9);
        want = (addr == 16'h5FFB) ? exp_rd : exp_rc;
        ti_a = addr; ti_memen = 1'b0; ti_dbin = 1'b1;
        tick(4);
        chk({tag, "_oe"}, tipi_data_out, !hit);
        if (hit) chk({tag, "_dout"}, ti_dout, want);
        ti_dbin = 1'b0; ti_memen = 1'b1;
        tick(4);
        chk({tag, "_oe_off"}, tipi_data_out, 1'b1);
        if (addr == 16'h5FFB) exp_rdp = 1'b0;
        if (addr == 16'h5FF9) exp_rcp = 1'b0;
        chk({tag, "_pend"}, {rd_pending, rc_pending}, {exp_rdp, exp_rcp});
    endtask

    initial begin
        int errs;
        logic oe_seen;
        logic [15:0] v;
        int n;
        logic rt;

        rst_n = 1'b0;
        tick(3);
        chk("rst_rd", rd_q, 8'h00);
        chk("rst_rc", rc_q, 8'h00);
        chk("rst_dout", ti_dout, 8'h00);
        chk("rst_oe", tipi_data_out, 1'b1);
        chk("rst_pend", {rd_pending, rc_pending}, 2'b00);
        chk("rst_err", frame_err, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // Commit timing: RD appears exactly three cycles after the latch edge.
        send_bits(16'h00A5, 8);
        r_rt = 1'b0;
        tick(1);
        r_le = 1'b1;
        tick(2);
        chk("a5_early", rd_q, 8'h00);
        tick(1);
        chk("a5_rd", rd_q, 8'hA5);
        chk("a5_pend", rd_pending, 1'b1);
        chk("a5_rc", rc_q, 8'h00);
        r_le = 1'b0;
        tick(6);
        exp_rd = 8'hA5; exp_rdp = 1'b1;

        frame("rc3c", 16'h003C, 8, 1'b1);
        ti_read("rd_rc", 16'h5FF9);

        // A read of the TI->RPi address never enables the transmitter.
        ti_a = 16'h5FFF; ti_memen = 1'b0; ti_dbin = 1'b1;
        oe_seen = 1'b0;
        repeat (8) begin tick(1); if (!tipi_data_out) oe_seen = 1'b1; end
        ti_dbin = 1'b0; ti_memen = 1'b1;
        tick(4);
        chk("rd_5fff_oe", oe_seen, 1'b0);

        frame("short7", 16'h0055, 7, 1'b0);
        frame("long10", 16'h02CE, 10, 1'b0);
        frame("after10", 16'h0011, 8, 1'b0);

        // Collision: RD read held open while a new RD byte is committed.
        ti_a = 16'h5FFB; ti_memen = 1'b0; ti_dbin = 1'b1;
        tick(4);
        chk("col_dout0", ti_dout, 8'h11);
        send_bits(16'h0022, 8);
        commit(1'b0, errs);
        chk("col_err", errs, 0);
        chk("col_dout1", ti_dout, 8'h11);
        chk("col_rd_held", rd_q, 8'h11);
        chk("col_oe", tipi_data_out, 1'b0);
        ti_dbin = 1'b0; ti_memen = 1'b1;
        tick(2);
        chk("col_rd_still", rd_q, 8'h11);
        tick(1);
        chk("col_rd_new", rd_q, 8'h22);
        chk("col_pend", rd_pending, 1'b1);
        exp_rd = 8'h22; exp_rdp = 1'b1;
        tick(4);

        // Latch and shift edges together: the extra bit must be dropped.
        send_bits(16'h0096, 8);
        r_rt = 1'b0; r_dout = 1'b1;
        tick(1);
        r_le = 1'b1; r_clk = 1'b1;
        errs = 0;
        repeat (5) begin tick(1); errs += int'(frame_err); end
        r_le = 1'b0; r_clk = 1'b0;
        repeat (5) begin tick(1); errs += int'(frame_err); end
        chk("sim_err", errs, 0);
        chk("sim_rd", rd_q, 8'h96);
        exp_rd = 8'h96;
        frame("sim_next7", 16'h0033, 7, 1'b0);
        frame("sim_next8", 16'h00C3, 8, 1'b0);

        // Reset mid-frame drops the partial bits.
        send_bits(16'h000F, 4);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        exp_rd = 8'h00; exp_rc = 8'h00; exp_rdp = 1'b0; exp_rcp = 1'b0;
        tick(2);
        chk("mid_rst_rd", rd_q, 8'h00);
        frame("mid_rst8", 16'h005A, 8, 1'b1);

        for (int k = 0; k < 20; k++) begin
            v  = 16'($urandom);
            n  = int'($urandom_range(6, 10));
            rt = 1'($urandom);
            frame($sformatf("rnd%0d", k), v, n, rt);
            if ((k % 4) == 3)
                ti_read($sformatf("rnd_rd%0d", k), ($urandom_range(0, 1) == 0) ? 16'h5FFB : 16'h5FF9);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tipi_rpi_to_ti.md
# tipi_rpi_to_ti

Return path of the TIPI mailbox: carries bytes from the Raspberry Pi to the TI-99/4A. The RPi shifts bytes serially over GPIO into one of two byte registers, RD (data) and RC (control). The TI reads these registers as memory at 0x5FFB and 0x5FFD-adjacent 0x5FF9, and the block drives the TI data bus transmitter enable during those reads. It is the counterpart of the TI→RPi latch path (TD/TC at 0x5FFF/0x5FFD), shares the 50 MHz fabric clock, and treats every TI and RPi input as asynchronous.

## Interface
- SYNC_STAGES, 2, flop depth of each input synchronizer (≥2)
- ADDR_RD, 16'h5FFB, TI address of the RPi→TI data register
- ADDR_RC, 16'h5FF9, TI address of the RPi→TI control register

- clk  in  1  50 MHz fabric clock; only clock in the block
- rst_n  in  1  reset, synchronous, active-low
- r_clk  in  1  RPi shift clock; a bit is taken on each rising edge
- r_dout  in  1  RPi serial data, MSB first
- r_le  in  1  RPi latch enable; a rising edge commits the frame
- r_rt  in  1  register target sampled with r_le: 0 = RD, 1 = RC
- ti_a  in  [0:15]  TI address, bit 0 = MSB
- ti_memen  in  1  TI memory enable, active low
- ti_dbin  in  1  TI read strobe, active high
- ti_dout  out  8  byte presented to the TI bus transmitter, bit 7 = MSB
- tipi_data_out  out  1  bus transmitter OE*, active low
- rd_q, rc_q  out  8 each  current RD/RC contents, for LEDs/debug
- rd_pending, rc_pending  out  1 each  set on commit, cleared when the TI finishes reading that register
- frame_err  out  1  one-cycle pulse on a malformed frame

## Operation
- Synchronizers: r_clk, r_dout, r_le, r_rt, ti_memen and ti_dbin each pass through SYNC_STAGES flops. ti_a passes through a single register stage. Edges are detected on the synchronized values against a one-cycle-delayed copy.
- Shift: on a synchronized r_clk rising edge, sh <= {sh[6:0], r_dout_s} and bit count cnt increments, saturating at 9. If cnt reaches 9, the frame is overrun; shifting continues, so sh always holds the last 8 bits.
- Commit: on a synchronized r_le rising edge:
  - if cnt == 8, sh is written to RD (r_rt_s = 0) or RC (r_rt_s = 1), and the matching pending bit is set on the same cycle as the write;
  - otherwise nothing is written and frame_err pulses;
  - in both cases cnt is cleared to 0.
- Simultaneous r_le and r_clk edges in one cycle: r_le wins. The commit uses the old sh/cnt and the clock edge is discarded.
- TI read: rd_act = ~memen_s & dbin_s & (a_q == ADDR_RD); rc_act is the same with ADDR_RC. While either is active:
  - tipi_data_out = 0;
  - ti_dout = the selected register.
  - Otherwise tipi_data_out = 1 and ti_dout holds its last value.
- Pending clear: on the falling edge of rd_act, rd_pending clears (likewise rc_act/rc_pending). If a commit to the same register lands in that same cycle, set wins.
- Read collision: if a commit targets the register currently being driven (its *_act = 1), the byte is parked in a one-entry shadow, and the register and ti_dout stay stable. The shadow is applied, and pending is set, on the first cycle after *_act falls; in that case pending stays set rather than clearing. A second commit to the parked register overwrites the shadow. A commit to the other register proceeds normally.

## Timing
- Reset (rst_n low at a clk edge):
  - rd_q = rc_q = 8'h00, ti_dout = 8'h00, tipi_data_out = 1, pending = 0, frame_err = 0;
  - cnt = 0, shadow empty, all synchronizers cleared to their idle values (memen 1, dbin 0, r_* 0).
- Reset mid-frame discards the partial frame and any parked shadow.
- RPi edge to internal action: SYNC_STAGES + 1 cycles (3 at default).
- Commit to rd_q/rc_q and pending visible: SYNC_STAGES + 1 cycles after the r_le edge.
- TI strobe to tipi_data_out low: SYNC_STAGES + 1 cycles (60 ns at default). This is well inside the TI 333 ns read cycle.
- tipi_data_out deassertion: SYNC_STAGES + 1 cycles after ~memen or dbin falls.
- The RPi must hold r_clk high and low for ≥ SYNC_STAGES + 1 cycles each, and keep r_dout and r_rt stable across their respective edges.

## Test plan
- Reset: hold rst_n low 3 cycles → all outputs at their reset values; tipi_data_out = 1.
- Shift 8'hA5 with r_rt = 0, then pulse r_le → rd_q = 8'hA5 and rd_pending = 1 three cycles after the edge; rc_q is still 0.
- TI read at 0x5FF9 after an RC commit of 8'h3C → tipi_data_out low, ti_dout = 8'h3C. Releasing dbin → OE high and rc_pending = 0. A read at 0x5FFF never asserts OE.
- Shift 7 bits then r_le → frame_err pulse, rd_q unchanged. Shift 10 bits (1011001110) then r_le → frame_err pulse, cnt back to 0.
- Collision: TI holding a read of RD (8'h11) while the RPi commits 8'h22 → ti_dout stays 8'h11 during the read. rd_q = 8'h22 one cycle after rd_act falls, and rd_pending = 1.
- Simultaneous r_le and r_clk edge after exactly 8 bits → commit succeeds, extra bit ignored, next frame starts at cnt = 0.
